dff_skid_stage: RTL and testbench

//  Two-entry valid/ready pipeline register (skid buffer) built on load-enable flops.

---
 rtl/dff_skid_stage.sv | 114 +++++++++++
 tb/tb_dff_skid_stage.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/dff_skid_stage.sv
// Two-entry valid/ready skid buffer built from load-enable registers.
// The upstream ready is a flop, so m_ready never reaches s_ready through
// combinational logic. The buffer still moves one item per cycle while both
// sides are streaming.
module dff_skid_stage #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [1:0]            occ
);

    // The encoding equals the number of entries held, so occ is the state itself.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic                  s_ready_q, s_ready_d;
    logic [DATA_WIDTH-1:0] main_q, main_d;
    logic [DATA_WIDTH-1:0] skid_q, skid_d;
    logic                  main_en, skid_en;
    logic                  s_fire, m_fire;

    assign m_valid = (state_q != EMPTY);
    assign s_ready = s_ready_q;
    assign m_data  = main_q;
    assign occ     = state_q;

    assign s_fire = s_valid & s_ready_q;
    assign m_fire = m_valid & m_ready;

    // Next-state and register load enables derived from the two handshakes.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        main_en = 1'b0;
        skid_en = 1'b0;
        unique case (state_q)
            EMPTY: begin
                if (s_fire) begin
                    state_d = ONE;
                    main_en = 1'b1;
                    main_d  = s_data;
                end
            end
            ONE: begin
                if (s_fire && !m_fire) begin
                    state_d = FULL;
                    skid_en = 1'b1;
                    skid_d  = s_data;
                end else if (!s_fire && m_fire) begin
                    state_d = EMPTY;
                end else if (s_fire && m_fire) begin
                    // The outgoing item leaves as the new one lands in main.
                    main_en = 1'b1;
                    main_d  = s_data;
                end
            end
            FULL: begin
                // s_ready is low here, so only the downstream side can move.
                if (m_fire) begin
                    state_d = ONE;
                    main_en = 1'b1;
                    main_d  = skid_q;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
        // Ready looks one state ahead so the stage can register it.
        s_ready_d = (state_d != FULL);
    end

    // State and ready flops. Ready stays low during reset and rises one edge after release.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= EMPTY;
            s_ready_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            s_ready_q <= s_ready_d;
        end
    end

    // Main register loads only on its enable, so m_data holds still during stalls.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            main_q <= '0;
        end else if (main_en) begin
            main_q <= main_d;
        end
    end

    // The skid register captures the item that arrives while main is stalled.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            skid_q <= '0;
        end else if (skid_en) begin
            skid_q <= skid_d;
        end
    end

endmodule

// File: tb/tb_dff_skid_stage.sv
// Directed bench for dff_skid_stage. It also runs a random phase that is checked against a queue model.
module tb_dff_skid_stage;

    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rstn = 1'b1;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [DW-1:0] s_data = '0;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [DW-1:0] m_data;
    logic [1:0]    occ;

    int checks = 0;
    int failures = 0;

    dff_skid_stage #(.DATA_WIDTH(DW)) dut (
        .clk     (clk),
        .rstn    (rstn),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .occ     (occ)
    );

    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [DW-1:0] q[$];
    logic          mdl_rdy;
    logic          sv, mr, sf, mf;
    int            pushed;
    logic [DW-1:0] nxt;

    initial begin
        // T1: reset with random inputs
        #1 rstn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            s_valid = 1'($urandom);
            m_ready = 1'($urandom);
            s_data  = 16'($urandom);
            step();
        end
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_s_ready", 32'(s_ready), 32'd0);
        chk("rst_m_data", 32'(m_data), 32'd0);
        chk("rst_occ", 32'(occ), 32'd0);
        rstn    = 1'b1;
        s_valid = 1'b1;
        s_data  = 16'h0007;
        m_ready = 1'b0;
        #1;
        chk("rel_s_ready_before_edge", 32'(s_ready), 32'd0);
        step();
        chk("rel_s_ready_after_edge", 32'(s_ready), 32'd1);
        chk("rel_no_accept_occ", 32'(occ), 32'd0);
        chk("rel_no_accept_m_valid", 32'(m_valid), 32'd0);

        // T2: single transfer
        s_valid = 1'b1;
        s_data  = 16'hA5A5;
        m_ready = 1'b1;
        step();
        s_valid = 1'b0;
        chk("single_m_valid", 32'(m_valid), 32'd1);
        chk("single_m_data", 32'(m_data), 32'hA5A5);
        chk("single_occ1", 32'(occ), 32'd1);
        step();
        chk("single_occ0", 32'(occ), 32'd0);
        chk("single_drained", 32'(m_valid), 32'd0);

        // T3: stall to full, then drain in order
        m_ready = 1'b0;
        s_valid = 1'b1;
        s_data  = 16'h0001;
        step();
        chk("stall_occ1", 32'(occ), 32'd1);
        chk("stall_ready1", 32'(s_ready), 32'd1);
        s_data = 16'h0002;
        step();
        chk("stall_occ2", 32'(occ), 32'd2);
        chk("stall_ready0", 32'(s_ready), 32'd0);
        chk("stall_head", 32'(m_data), 32'h0001);
        s_data = 16'h0003;
        step();
        step();
        chk("stall_held_occ", 32'(occ), 32'd2);
        chk("stall_held_data", 32'(m_data), 32'h0001);
        chk("stall_held_valid", 32'(m_valid), 32'd1);
        m_ready = 1'b1;
        step();
        chk("drain_item2", 32'(m_data), 32'h0002);
        chk("drain_occ_a", 32'(occ), 32'd1);
        chk("drain_ready", 32'(s_ready), 32'd1);
        step();
        s_valid = 1'b0;
        chk("drain_item3", 32'(m_data), 32'h0003);
        chk("drain_occ_b", 32'(occ), 32'd1);
        step();
        chk("drain_empty", 32'(occ), 32'd0);

        // T4: streaming at full rate
        s_valid = 1'b1;
        m_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            s_data = 16'(i + 16'h0100);
            step();
            chk("stream_data", 32'(m_data), 32'(i + 16'h0100));
            chk("stream_occ", 32'(occ), 32'd1);
            chk("stream_ready", 32'(s_ready), 32'd1);
        end
        s_valid = 1'b0;
        step();
        chk("stream_end_occ", 32'(occ), 32'd0);

        // T5: random handshakes against a queue model
        mdl_rdy = 1'b1;
        pushed  = 0;
        nxt     = 16'h1000;
        while (pushed < 2000) begin
            sv = 1'($urandom_range(0, 2) != 0);
            mr = 1'($urandom_range(0, 2) != 0);
            s_valid = sv;
            m_ready = mr;
            s_data  = nxt;
            sf = sv & mdl_rdy;
            mf = (q.size() > 0) & mr;
            if (mf) void'(q.pop_front());
            if (sf) begin
                q.push_back(nxt);
                nxt++;
                pushed++;
            end
            mdl_rdy = (q.size() != 2);
            step();
            chk("rand_occ", 32'(occ), 32'(q.size()));
            chk("rand_ready", 32'(s_ready), 32'(mdl_rdy));
            chk("rand_valid", 32'(m_valid), 32'(q.size() > 0));
            if (q.size() > 0) chk("rand_data", 32'(m_data), 32'(q[0]));
        end
        s_valid = 1'b0;
        m_ready = 1'b1;
        step();
        step();
        chk("rand_drained", 32'(occ), 32'd0);

        // T6: reset while full
        m_ready = 1'b0;
        s_valid = 1'b1;
        s_data  = 16'h0001;
        step();
        s_data = 16'h0002;
        step();
        chk("midrst_full", 32'(occ), 32'd2);
        rstn = 1'b0;
        #1;
        chk("midrst_m_valid", 32'(m_valid), 32'd0);
        chk("midrst_occ", 32'(occ), 32'd0);
        chk("midrst_s_ready", 32'(s_ready), 32'd0);
        chk("midrst_m_data", 32'(m_data), 32'd0);
        step();
        rstn    = 1'b1;
        s_valid = 1'b0;
        m_ready = 1'b1;
        step();
        chk("midrst_ready_back", 32'(s_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            chk("midrst_no_stale", 32'(m_valid), 32'd0);
            step();
        end
        s_valid = 1'b1;
        s_data  = 16'h00AA;
        step();
        s_valid = 1'b0;
        chk("midrst_fresh_data", 32'(m_data), 32'h00AA);
        chk("midrst_fresh_valid", 32'(m_valid), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
